iter_shift_unit: RTL and testbench

- Parametrised multi-cycle shift/rotate unit with a start/done handshake, variable shift amount and status flags.
- Next-generation replacement for the single-step shifter.
- Performs one 1-bit step per clock, so a shift by N completes N+1 cycles after acceptance.
- Sits beside the ALU in the datapath; the controller issues `start` and waits for `done`.

---
 rtl/iter_shift_unit.sv | 142 ++++++++++++++
 tb/tb_iter_shift_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate unit: one 1-bit step per clock with a start/done handshake.
// Q, carry and zero update only on entry to DONE; intermediate steps stay internal.
module iter_shift_unit #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   D,
  input  logic [3:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   Q,
  output logic               busy,
  output logic               done,
  output logic               carry,
  output logic               zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_LSL = 4'b0001,
    OP_LSR = 4'b0010,
    OP_ROR = 4'b0011,
    OP_ROL = 4'b0100,
    OP_ASR = 4'b0101
  } op_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     w_q, w_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]           m_q, m_d;
  logic                 cin_q, cin_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;

  function automatic logic is_shift(input logic [3:0] m);
    return (m == OP_LSL) || (m == OP_LSR) || (m == OP_ROR) ||
           (m == OP_ROL) || (m == OP_ASR);
  endfunction

  // Returns {bit leaving W, stepped W}.
  function automatic logic [WIDTH:0] step(input logic [WIDTH-1:0] w, input logic [3:0] m);
    logic [WIDTH:0] r;
    case (m)
      OP_LSL:  r = {w[WIDTH-1], w[WIDTH-2:0], 1'b0};
      OP_LSR:  r = {w[0], 1'b0, w[WIDTH-1:1]};
      OP_ROR:  r = {w[0], w[0], w[WIDTH-1:1]};
      OP_ROL:  r = {w[WIDTH-1], w[WIDTH-2:0], w[WIDTH-1]};
      OP_ASR:  r = {w[0], w[WIDTH-1], w[WIDTH-1:1]};
      default: r = {1'b0, w};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ((shamt != '0) && is_shift(mode)) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Q is taken from the next W so a zero-step op publishes D on the same edge it is loaded.
  always_comb begin
    w_d     = w_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    cin_d   = cin_q;
    q_d     = q_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (state_q == IDLE && start) begin
      w_d   = D;
      m_d   = mode;
      cnt_d = shamt;
      cin_d = 1'b0;
    end else if (state_q == SHIFT) begin
      {cin_d, w_d} = step(w_q, m_q);
      cnt_d        = cnt_q - SHAMT_W'(1);
    end
    if (state_d == DONE && state_q != DONE) begin
      q_d     = w_d;
      carry_d = cin_d;
      zero_d  = (w_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q     <= '0;
      cnt_q   <= '0;
      m_q     <= '0;
      cin_q   <= 1'b0;
      q_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      cin_q   <= cin_d;
      q_q     <= q_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign Q     = q_q;
  assign carry = carry_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed and randomised checks of iter_shift_unit with a result scoreboard.
module tb_iter_shift_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] D;
  logic [3:0] mode;
  logic [3:0] shamt;
  logic [7:0] Q;
  logic       busy, done, carry, zero;

  typedef struct {
    logic [7:0] q;
    logic       c;
    logic       z;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   edges  = 0;
  int   errors = 0;
  int   checks = 0;

  iter_shift_unit #(.WIDTH(8), .SHAMT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .D     (D),
    .mode  (mode),
    .shamt (shamt),
    .Q     (Q),
    .busy  (busy),
    .done  (done),
    .carry (carry),
    .zero  (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model built from closed-form shift operators, not from stepping.
  function automatic exp_t model(input logic [7:0] d, input logic [3:0] m, input int n);
    exp_t        e;
    logic [15:0] t;
    logic signed [7:0] s;
    int          k;
    k = n % 8;
    e.c = 1'b0;
    case (m)
      4'd1: begin
        e.q = (n >= 8) ? 8'h00 : d << n;
        if (n != 0 && n <= 8) e.c = d[8-n];
      end
      4'd2: begin
        e.q = (n >= 8) ? 8'h00 : d >> n;
        if (n != 0 && n <= 8) e.c = d[n-1];
      end
      4'd3: begin
        t = {d, d} >> k;
        e.q = t[7:0];
        if (n != 0) e.c = e.q[7];
      end
      4'd4: begin
        t = {d, d} << k;
        e.q = t[15:8];
        if (n != 0) e.c = e.q[0];
      end
      4'd5: begin
        s = d;
        e.q = s >>> n;
        if (n != 0) e.c = (n <= 8) ? d[n-1] : d[7];
      end
      default: e.q = d;
    endcase
    e.z  = (e.q == 8'h00);
    e.at = (m >= 4'd1 && m <= 4'd5 && n != 0) ? n + 1 : 1;
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("Q", Q, e.q);
        chk("carry", carry, e.c);
        chk("zero", zero, e.z);
        chk("done_cycle", edges, e.at);
      end
    end
  end

  task automatic wait_idle();
    @(negedge clk);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    if (busy) chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic issue(input logic [7:0] d, input logic [3:0] m, input logic [3:0] n, input exp_t e);
    exp_t x;
    wait_idle();
    start = 1'b1; D = d; mode = m; shamt = n;
    x = e;
    x.at = edges + e.at;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0; D = 8'($urandom); mode = 4'($urandom); shamt = 4'($urandom);
  endtask

  function automatic exp_t mk(input logic [7:0] q, input logic c, input int lat);
    exp_t e;
    e.q = q; e.c = c; e.z = (q == 8'h00); e.at = lat;
    return e;
  endfunction

  initial begin
    exp_t e;
    rst = 1'b1; start = 1'b0; D = '0; mode = '0; shamt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_Q", Q, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_carry", carry, 1'b0);
    chk("rst_zero", zero, 1'b0);
    rst = 1'b0;

    issue(8'h96, 4'b0001, 4'd3, mk(8'hB0, 1'b0, 4));
    for (int i = 1; i <= 4; i++) begin
      chk("busy_lsl", busy, 1'b1);
      @(negedge clk);
    end
    chk("busy_after", busy, 1'b0);

    issue(8'h96, 4'b0101, 4'd2,  mk(8'hE5, 1'b1, 3));
    issue(8'h81, 4'b0100, 4'd1,  mk(8'h03, 1'b1, 2));
    issue(8'h96, 4'b0011, 4'd8,  mk(8'h96, 1'b1, 9));
    issue(8'h96, 4'b0010, 4'd15, mk(8'h00, 1'b0, 16));
    issue(8'h5A, 4'b0010, 4'd0,  mk(8'h5A, 1'b0, 1));
    issue(8'h3C, 4'b1111, 4'd7,  mk(8'h3C, 1'b0, 1));

    // start while busy must be ignored
    issue(8'h01, 4'b0001, 4'd6, mk(8'h40, 1'b0, 7));
    @(negedge clk);
    start = 1'b1; D = 8'hFF; mode = 4'b0001; shamt = 4'd2;
    @(negedge clk);
    start = 1'b0;
    chk("Q_hold", Q, 8'h3C);

    // reset mid-operation abandons it
    issue(8'h01, 4'b0001, 4'd6, mk(8'h40, 1'b0, 7));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_Q", Q, 8'h00);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // back-to-back with start held high
    wait_idle();
    start = 1'b1; D = 8'h01; mode = 4'b0011; shamt = 4'd1;
    e = mk(8'h80, 1'b1, 0); e.at = edges + 2; sb.push_back(e);
    e = mk(8'h02, 1'b0, 0); e.at = edges + 5; sb.push_back(e);
    @(negedge clk);
    D = 8'h01; mode = 4'b0001; shamt = 4'd1;
    repeat (3) @(negedge clk);
    start = 1'b0;

    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      logic [3:0] m;
      logic [3:0] n;
      d = 8'($urandom);
      m = 4'($urandom_range(0, 6));
      n = 4'($urandom_range(0, 15));
      issue(d, m, n, model(d, m, int'(n)));
    end

    wait_idle();
    repeat (2) @(negedge clk);
    chk("drain", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
